// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the framed SPI receiver.
// The state encoding and the SPI mode helper live here.
package spi_rx_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        DATA       = 3'd2,
        DROP       = 3'd3,
        WAIT_DESEL = 3'd4
    } state_t;

    localparam int MODE0 = 0;
    localparam int MODE1 = 1;
    localparam int MODE2 = 2;
    localparam int MODE3 = 3;

    // Modes 0 and 3 sample on rising SCK; modes 1 and 2 sample on falling SCK.
    function automatic logic sample_on_rise(input int mode);
        logic rise;
        if ((mode == MODE0) || (mode == MODE3)) begin
            rise = 1'b1;
        end else begin
            rise = 1'b0;
        end
        return rise;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with registered
// rise/fall pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Synchronise the pin, then compare against the previous synchronised value.
    // Resetting to 0 means a pin that is high at reset appears as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            prev_r  <= chain_r[STAGES-1];
            rise_r  <= chain_r[STAGES-1] & ~prev_r;
            fall_r  <= ~chain_r[STAGES-1] & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI receiver: parses address word + data words into a
// register bank with auto-incrementing, wrapping address.
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 4,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sck,
    input  logic                         cs,
    input  logic                         mosi,
    output logic                         word_valid,
    output logic [DATA_W-1:0]            word_data,
    output logic                         wr_en,
    output logic [AW-1:0]                wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic                         frame_active,
    output logic                         frame_err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

    localparam int   CW          = $clog2(DATA_W);
    localparam logic SAMPLE_RISE = sample_on_rise(MODE);

    state_t                  state_r;
    logic [SYNC_STAGES-1:0]  mosi_chain_r;
    logic                    mosi_bit_r;
    logic [CW-1:0]           bit_cnt_r;
    logic [DATA_W-1:0]       shift_r;
    logic [AW-1:0]           addr_ptr_r;
    logic                    word_valid_r;
    logic [DATA_W-1:0]       word_data_r;
    logic                    wr_en_r;
    logic [AW-1:0]           wr_addr_r;
    logic [DATA_W-1:0]       wr_data_r;
    logic                    frame_active_r;
    logic                    frame_err_r;
    logic [DATA_W-1:0]       regs_r [NUM_REGS];

    logic                    sck_rise_s;
    logic                    sck_fall_s;
    logic                    cs_rise_s;
    logic                    cs_fall_s;
    logic                    sample_s;
    logic                    shift_en_s;
    logic                    last_bit_s;
    logic [DATA_W-1:0]       next_word_s;
    logic                    addr_ok_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .rise  (sck_rise_s),
        .fall  (sck_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    // MOSI gets one extra flop so its bit lines up with the registered SCK edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_chain_r <= '0;
            mosi_bit_r   <= 1'b0;
        end else begin
            mosi_chain_r <= {mosi_chain_r[SYNC_STAGES-2:0], mosi};
            mosi_bit_r   <= mosi_chain_r[SYNC_STAGES-1];
        end
    end

    // Sampling edge select and word-completion decode; a cs rise overrides the edge.
    always_comb begin
        if (SAMPLE_RISE) begin
            sample_s = sck_rise_s;
        end else begin
            sample_s = sck_fall_s;
        end
        if ((state_r == ADDR) || (state_r == DATA) || (state_r == DROP)) begin
            shift_en_s = sample_s & ~cs_rise_s;
        end else begin
            shift_en_s = 1'b0;
        end
        next_word_s = {shift_r[DATA_W-2:0], mosi_bit_r};
        last_bit_s  = (bit_cnt_r == CW'(DATA_W - 1));
        addr_ok_s   = ({{(32-DATA_W){1'b0}}, next_word_s} < 32'(NUM_REGS));
    end

    // Frame FSM with shift register, bit counter, address pointer and strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= WAIT_DESEL;
            bit_cnt_r      <= '0;
            shift_r        <= '0;
            addr_ptr_r     <= '0;
            word_valid_r   <= 1'b0;
            word_data_r    <= '0;
            wr_en_r        <= 1'b0;
            wr_addr_r      <= '0;
            wr_data_r      <= '0;
            frame_active_r <= 1'b0;
            frame_err_r    <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            wr_en_r      <= 1'b0;
            if (shift_en_s) begin
                shift_r   <= next_word_s;
                bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + CW'(1);
                if (last_bit_s) begin
                    word_valid_r <= 1'b1;
                    word_data_r  <= next_word_s;
                end
            end
            case (state_r)
                WAIT_DESEL: begin
                    if (cs_rise_s) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall_s) begin
                        frame_err_r    <= 1'b0;
                        bit_cnt_r      <= '0;
                        frame_active_r <= 1'b1;
                        state_r        <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    if (cs_rise_s) begin
                        if (bit_cnt_r != '0) begin
                            frame_err_r <= 1'b1;
                        end
                        frame_active_r <= 1'b0;
                        state_r        <= IDLE;
                    end else if (shift_en_s && last_bit_s) begin
                        if (state_r == ADDR) begin
                            if (addr_ok_s) begin
                                addr_ptr_r <= next_word_s[AW-1:0];
                                state_r    <= DATA;
                            end else begin
                                frame_err_r    <= 1'b1;
                                frame_active_r <= 1'b0;
                                state_r        <= DROP;
                            end
                        end else begin
                            wr_en_r    <= 1'b1;
                            wr_addr_r  <= addr_ptr_r;
                            wr_data_r  <= next_word_s;
                            addr_ptr_r <= (addr_ptr_r == AW'(NUM_REGS - 1)) ? '0
                                                                           : addr_ptr_r + AW'(1);
                        end
                    end
                end
                DROP: begin
                    if (cs_rise_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    frame_active_r <= 1'b0;
                    state_r        <= WAIT_DESEL;
                end
            endcase
        end
    end

    // Register bank follows the write strobe by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_r) begin
            regs_r[wr_addr_r] <= wr_data_r;
        end
    end

    // Flatten the bank for the colour-mixing logic.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_r[i];
        end
    end

    assign word_valid   = word_valid_r;
    assign word_data    = word_data_r;
    assign wr_en        = wr_en_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign frame_active = frame_active_r;
    assign frame_err    = frame_err_r;

endmodule
